// File: rtl/ram_rd_stream_pkg.sv
// rtl/ram_rd_stream_pkg.sv - shared state encoding and skid FIFO sizing for ram_rd_stream
package ram_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    // Reads in flight plus words buffered may never exceed the FIFO depth.
    localparam int CREDIT_LIMIT = SKID_DEPTH;
    localparam int COUNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_rd_stream_skid_fifo.sv
// rtl/ram_rd_stream_skid_fifo.sv - 2-entry shift FIFO with registered head entry
module rd_skid_fifo
    import ram_rd_stream_pkg::*;
#(
    parameter int W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic [W-1:0]       head,
    output logic [COUNT_W-1:0] count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;

    // entry0 is always the head, so the output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) entry0 <= din;
                    else             entry1 <= din;
                    count <= count + COUNT_W'(1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - COUNT_W'(1);
                end
                2'b11: begin
                    if (count == COUNT_W'(1)) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0;

endmodule

// File: rtl/ram_rd_stream.sv
// rtl/ram_rd_stream.sv - streams a RAM address range out on valid/ready
// Optional clear-on-read write-back enabled by macro RAM_RD_STREAM_CLEAR_EN.
module ram_rd_stream
    import ram_rd_stream_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [AWID-1:0] i_base,
    input  logic [AWID:0]   i_len,
    output logic            o_busy,
    output logic            o_done,
    output logic [AWID-1:0] o_ram_addr,
    output logic            o_ram_we,
    output logic [DWID-1:0] o_ram_wdata,
    input  logic [DWID-1:0] i_ram_rdata,
    output logic            o_valid,
    output logic [DWID-1:0] o_data,
    output logic            o_last,
    input  logic            i_ready
);

    if (DEPTH != (1 << AWID)) begin : g_bad_depth
        $error("DEPTH must equal 2**AWID");
    end

    state_t               state_q, state_d;
    logic [AWID-1:0]      cur_addr_q;
    logic [AWID-1:0]      last_addr_q;
    logic [AWID:0]        remaining_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [COUNT_W-1:0]   fifo_count;
    logic [DWID:0]        fifo_head;
    logic [COUNT_W:0]     credit_used;
    logic                 issue;
    logic                 pop;
    logic                 final_issue;

    assign pop         = o_valid & i_ready;
    assign credit_used = {1'b0, fifo_count} + {{COUNT_W{1'b0}}, inflight_q}
                       - {{COUNT_W{1'b0}}, pop};
    assign issue       = (state_q == ST_RUN) && (remaining_q != '0)
                       && (credit_used < (COUNT_W+1)'(CREDIT_LIMIT));
    assign final_issue = issue && (remaining_q == (AWID+1)'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = (i_len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (final_issue) state_d = ST_DRAIN;
            // Leave as soon as the last buffered word is handshaking this cycle.
            ST_DRAIN: if (!inflight_q && ((fifo_count == '0) ||
                          (fifo_count == COUNT_W'(1) && pop))) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cur_addr_q      <= '0;
            last_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= final_issue;
            if (state_q == ST_IDLE && i_start) begin
                cur_addr_q  <= i_base;
                remaining_q <= i_len;
            end
            if (issue) begin
                cur_addr_q  <= cur_addr_q + AWID'(1);
                last_addr_q <= cur_addr_q;
                remaining_q <= remaining_q - (AWID+1)'(1);
            end
        end
    end

    rd_skid_fifo #(.W(DWID + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({inflight_last_q, i_ram_rdata}),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_ram_addr = issue ? cur_addr_q : last_addr_q;
    assign o_valid    = (fifo_count != '0);
    assign o_data     = fifo_head[DWID-1:0];
    assign o_last     = o_valid & fifo_head[DWID];

`ifdef RAM_RD_STREAM_CLEAR_EN
    // Same-address write in the issue cycle; the RAM returns the old word first.
    assign o_ram_we    = issue;
    assign o_ram_wdata = '0;
`else
    assign o_ram_we    = 1'b0;
    assign o_ram_wdata = '0;
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb/tb_ram_rd_stream.sv - scoreboard bench for ram_rd_stream with a behavioural RAM
module tb_ram_rd_stream;

    localparam int AWID  = 8;
    localparam int DWID  = 16;
    localparam int DEPTH = 256;

    logic            clk;
    logic            rst;
    logic            i_start;
    logic [AWID-1:0] i_base;
    logic [AWID:0]   i_len;
    logic            o_busy;
    logic            o_done;
    logic [AWID-1:0] o_ram_addr;
    logic            o_ram_we;
    logic [DWID-1:0] o_ram_wdata;
    logic [DWID-1:0] ram_rdata;
    logic            o_valid;
    logic [DWID-1:0] o_data;
    logic            o_last;
    logic            i_ready;
    logic            load;

    logic [DWID-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;
    logic [DWID:0] exp_q [$];

    ram_rd_stream #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_addr  (o_ram_addr),
        .o_ram_we    (o_ram_we),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .i_ready     (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= DWID'(16'h0100 + a);
        end else begin
            ram_rdata <= mem[o_ram_addr];
            if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic          prev_stall = 1'b0;
    logic [DWID:0] prev_word  = '0;

    always @(negedge clk) begin
        logic [DWID:0] w;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {15'd0, o_valid, o_last, o_data}, {15'd0, 1'b1, prev_word});
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", {o_last, o_data});
                end else begin
                    w = exp_q.pop_front();
                    check("stream_word", {15'd0, o_last, o_data}, {15'd0, w});
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_word  = {o_last, o_data};
`ifdef RAM_RD_STREAM_CLEAR_EN
            if (!o_busy) check("we_idle", {31'd0, o_ram_we}, 32'd0);
`else
            check("we_tied", {15'd0, o_ram_we, o_ram_wdata}, 32'd0);
`endif
        end
    end

    function automatic logic ready_pat(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic run_cmd(input logic [AWID-1:0] base, input int len, input int mode,
                           input int exp_first, input int exp_done, input bit poke,
                           input bit zeros);
        int first;
        int done;
        for (int i = 0; i < len; i++) begin
            logic [AWID-1:0] a;
            a = base + AWID'(i);
            exp_q.push_back({(i == len - 1), zeros ? 16'h0000 : (16'h0100 + {8'h00, a})});
        end
        first = -1;
        done  = -1;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_base  = base;
        i_len   = (AWID+1)'(len);
        i_ready = ready_pat(mode, 0);
        @(negedge clk);
        check("busy_before_accept", {31'd0, o_busy}, 32'd0);
        for (int k = 1; k < 300 && done < 0; k++) begin
            @(posedge clk); #1;
            i_start = poke && (k == 2);
            if (poke) begin
                i_base = 8'h80;
                i_len  = 9'd1;
            end
            i_ready = ready_pat(mode, k);
            @(negedge clk);
            if (k == 1) check("busy_after_accept", {31'd0, o_busy}, 32'd1);
            if (o_valid && first < 0) first = k;
            if (o_done) done = k;
        end
        if (done < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done expected a pulse");
        end else if (exp_done >= 0) begin
            check("done_cycle", done, exp_done);
        end
        check("first_valid_cycle", first, exp_first);
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", {30'd0, o_done, o_busy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b1;
        i_start = 1'b0;
        i_base  = '0;
        i_len   = '0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check("reset_outputs", {3'd0, o_busy, o_done, o_valid, o_last, o_ram_we,
                                o_ram_addr, o_ram_wdata}, 32'd0);
        check("reset_data", {16'd0, o_data}, 32'd0);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_quiet", {23'd0, o_busy, o_ram_addr}, 32'd0);
        end

        run_cmd(8'h10, 4, 0, 3, 7, 1'b0, 1'b0);
        run_cmd(8'h10, 4, 1, 3, -1, 1'b0, 1'b0);
        run_cmd(8'hFE, 4, 0, 3, 7, 1'b0, 1'b0);
        run_cmd(8'h00, 0, 0, -1, 1, 1'b0, 1'b0);
        run_cmd(8'h30, 5, 0, 3, 8, 1'b1, 1'b0);

        @(posedge clk); #1;
        i_start = 1'b1;
        i_base  = 8'h40;
        i_len   = 9'd8;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'h0140 + 16'(i)});
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {3'd0, o_busy, o_done, o_valid, o_last, o_ram_we,
                                o_ram_addr, o_ram_wdata}, 32'd0);
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, o_done, o_valid}, 32'd0);
        end
        run_cmd(8'h50, 3, 0, 3, 6, 1'b0, 1'b0);

`ifdef RAM_RD_STREAM_CLEAR_EN
        run_cmd(8'h20, 3, 0, 3, 6, 1'b0, 1'b0);
        run_cmd(8'h20, 3, 0, 3, 6, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
